// File: rtl/mmio_uart_tx_if.sv
// Processor data-port view of the UART: store strobe, address and write data
// in; register read data and the read-mux select out.
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData,
        input  ReadData,
        input  sel
    );

    modport slave (
        input  MemWrite,
        input  DataAdr,
        input  WriteData,
        output ReadData,
        output sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA pushes a byte into a small FIFO,
// STATUS reports busy/full/empty/count/overflow, CTRL clears the overflow flag.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFF201000,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    mmio_uart_tx_if.slave    bus,
    output logic             tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e             state_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic sel_data_c;
    logic sel_stat_c;
    logic sel_ctrl_c;
    logic full_c;
    logic empty_c;
    logic busy_c;
    logic push_req_c;
    logic push_c;
    logic pop_c;
    logic overflow_c;
    logic ovf_clr_c;
    logic bit_end_c;
    logic unused_wdata;

    // Exact word-address decode; byte offsets and other words are ignored.
    assign sel_data_c = (bus.DataAdr == BASE_ADDR);
    assign sel_stat_c = (bus.DataAdr == (BASE_ADDR + 32'd4));
    assign sel_ctrl_c = (bus.DataAdr == (BASE_ADDR + 32'd8));

    assign full_c     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty_c    = (cnt_q == '0);
    assign busy_c     = (state_q != S_IDLE) || !empty_c;

    // A push when full is dropped even if a pop happens on the same edge.
    assign push_req_c = bus.MemWrite && sel_data_c;
    assign push_c     = push_req_c && !full_c;
    assign overflow_c = push_req_c && full_c;
    assign ovf_clr_c  = bus.MemWrite && sel_ctrl_c && bus.WriteData[0];
    assign pop_c      = (state_q == S_IDLE) && !empty_c;

    assign bit_end_c  = (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1));

    assign unused_wdata = ^bus.WriteData[31:8];

    assign bus.sel = sel_data_c || sel_stat_c || sel_ctrl_c;
    assign tx      = tx_q;

    // Only STATUS returns data; DATA and CTRL read as zero.
    always_comb begin
        bus.ReadData = '0;
        if (sel_stat_c) begin
            bus.ReadData[0]           = busy_c;
            bus.ReadData[1]           = full_c;
            bus.ReadData[2]           = empty_c;
            bus.ReadData[3 +: CNT_W]  = cnt_q;
            bus.ReadData[15]          = ovf_q;
        end
    end

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            // Setting beats clearing when both land on the same edge.
            if (overflow_c) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_c) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end_c) begin
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        bit_cnt_q <= '0;
                        if (idx_q == IDX_W'(7)) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        bit_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-level model (byte queue + position in frame)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFF201000;
    localparam logic [31:0] STAT  = 32'hFF201004;
    localparam logic [31:0] CTRL  = 32'hFF201008;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;

    logic clk;
    logic reset_n;
    logic tx;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .tx     (tx)
    );

    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: waiting bytes, whether a frame is on the wire and
    // how many cycles into its 10*CPB-cycle body we are.
    logic [7:0] mq[$];
    logic       m_active;
    int         m_t;
    logic [7:0] m_cur;
    logic       m_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_cur    = 8'h00;
            m_ovf    = 1'b0;
        end else begin
            int pre;
            pre = mq.size();
            if (m_active) begin
                m_t++;
                if (m_t == 10 * CPB) m_active = 1'b0;
            end else if (pre > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (bus.MemWrite && bus.DataAdr == CTRL && bus.WriteData[0]) m_ovf = 1'b0;
            if (bus.MemWrite && bus.DataAdr == BASE) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else mq.push_back(bus.WriteData[7:0]);
            end
        end
    end

    function automatic logic exp_tx();
        if (!m_active) return 1'b1;
        if (m_t < CPB) return 1'b0;
        if (m_t < 9 * CPB) return m_cur[(m_t - CPB) / CPB];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int n;
        int v;
        n = mq.size();
        if (a != STAT) return 32'h0;
        v = ((m_active || n > 0) ? 1 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 4 : 0)
            + n * 8 + (m_ovf ? 32768 : 0);
        return 32'(v);
    endfunction

    function automatic logic exp_sel(input logic [31:0] a);
        return (a == BASE) || (a == STAT) || (a == CTRL);
    endfunction

    always @(negedge clk) begin
        check("tx_model", 32'(tx), 32'(exp_tx()));
        check("rd_model", bus.ReadData, exp_rd(bus.DataAdr));
        check("sel_model", 32'(bus.sel), 32'(exp_sel(bus.DataAdr)));
    end

    // Independent line receiver sampling mid-bit, used for the literal byte checks.
    logic [7:0] rx_q[$];
    int         ph;
    logic [7:0] rsh;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph  = -1;
            rsh = 8'h00;
        end else if (ph < 0) begin
            if (tx == 1'b0) begin
                ph  = 0;
                rsh = 8'h00;
            end
        end else begin
            ph++;
            if (ph >= 6 && ph <= 34 && ((ph - 6) % 4) == 0) rsh[(ph - 6) / 4] = tx;
            if (ph == 38) rx_q.push_back(rsh);
            if (ph == 39) ph = -1;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Called 2 ns after a rising edge; the store lands on the next edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = a;
        bus.WriteData = d;
        @(posedge clk);
        #2;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = STAT;
        bus.WriteData = 32'h0;
    endtask

    task automatic wait_idle(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.ReadData[0] == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_wait", 32'(done), 32'h1);
    endtask

    initial begin
        logic [39:0] pat;
        reset_n       = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = STAT;
        bus.WriteData = 32'h0;
        rx_q.delete();

        // Reset
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_status", bus.ReadData, 32'h00000004);
        check("rst_sel_stat", 32'(bus.sel), 32'h1);
        bus.DataAdr = 32'hFF200000;
        #1;
        check("rst_sel_other", 32'(bus.sel), 32'h0);
        bus.DataAdr = STAT;

        // Single byte 0x55: start, LSB-first data, stop, in time order from bit 0
        sync();
        wr(BASE, 32'hABCD0055);
        @(negedge clk);
        check("sb_pre_tx", 32'(tx), 32'h1);
        pat = 40'hF0F0F0F0F0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("sb_wave", 32'(tx), 32'(pat[i]));
            if (i == 20) check("sb_busy", 32'(bus.ReadData[0]), 32'h1);
        end
        @(negedge clk);
        check("sb_done_tx", 32'(tx), 32'h1);
        check("sb_done_status", bus.ReadData, 32'h00000004);
        check("sb_rx_byte", 32'(rx_q.size() == 1 ? rx_q[0] : 8'hxx), 32'h55);

        // Overflow: six back-to-back stores, the sixth is dropped
        rx_q.delete();
        sync();
        for (int b = 1; b <= 6; b++) wr(BASE, 32'(b));
        #1;
        check("ovf_status", bus.ReadData, 32'h00008023);
        wait_idle(400);
        check("ovf_rx_count", 32'(rx_q.size()), 32'd5);
        for (int b = 0; b < 5 && b < rx_q.size(); b++) check("ovf_rx_byte", 32'(rx_q[b]), 32'(b + 1));
        check("ovf_sticky", bus.ReadData, 32'h00008004);
        sync();
        wr(CTRL, 32'h1);
        #1;
        check("ovf_cleared", bus.ReadData, 32'h00000004);

        // Reset during data bit 3 of a frame
        rx_q.delete();
        sync();
        wr(BASE, 32'h000000A5);
        repeat (18) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'h1);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("mid_rst_status", bus.ReadData, 32'h00000004);
        repeat (60) @(negedge clk);
        check("mid_rst_no_frame", 32'(rx_q.size()), 32'd0);
        check("mid_rst_tx_idle", 32'(tx), 32'h1);

        // Decode: near-miss addresses are ignored
        sync();
        wr(32'hFF20100C, 32'h77);
        wr(32'hFF201001, 32'h77);
        #1;
        check("dec_count", bus.ReadData, 32'h00000004);
        check("dec_tx", 32'(tx), 32'h1);
        bus.DataAdr = BASE;
        #1;
        check("dec_data_read", bus.ReadData, 32'h0);
        check("dec_data_sel", 32'(bus.sel), 32'h1);
        bus.DataAdr = STAT;
        sync();
        bus.DataAdr = CTRL;
        #1;
        check("dec_ctrl_read", bus.ReadData, 32'h0);
        bus.DataAdr = STAT;

        // Push on the same edge as the pop keeps count at 1
        rx_q.delete();
        sync();
        wr(BASE, 32'h11);
        wr(BASE, 32'h22);
        #1;
        check("pp_status", bus.ReadData, 32'h00000009);
        wait_idle(200);
        check("pp_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("pp_rx_first", 32'(rx_q[0]), 32'h11);
            check("pp_rx_second", 32'(rx_q[1]), 32'h22);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter for the single-cycle RISC-V system, located downstream of the processor's data-memory port beside the LED/HEX/switch I/O decode. The core writes bytes with `sw` to a data register; they enter a small FIFO and are serialised 8N1 on `tx`. A status register is readable with `lw` through the top-level read-data mux.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFF201000: word address of the DATA register.
  - STATUS is at BASE_ADDR+4.
  - CTRL is at BASE_ADDR+8.
- `CLKS_PER_BIT`, default 434: clocks per UART bit (50 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2, at least 2.

Ports:
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in 32: ALU result / data address from the core.
- `WriteData` in 32: store data from the core.
- `ReadData` out 32: register read data.
  - Combinational.
  - 32'b0 when not selected or when DATA/CTRL is addressed.
- `sel` out 1: combinational. High when DataAdr equals BASE_ADDR, BASE_ADDR+4 or BASE_ADDR+8. Top level uses it to steer its read mux.
- `tx` out 1: serial output. Idles high.

## Operation
- Address decode uses exact 32-bit word match. All other addresses are ignored, including byte offsets 1–3 and BASE_ADDR+12.
- DATA write (MemWrite & DataAdr==BASE_ADDR):
  - Pushes WriteData[7:0]; WriteData[31:8] is ignored.
  - If the FIFO count sampled before the edge equals FIFO_DEPTH, the push is dropped and sticky `ovf` is set. This holds even if a pop occurs on the same edge.
- CTRL write: WriteData[0]=1 clears `ovf`. Other bits are ignored. If a clear and an overflow occur on the same edge, the set wins.
- STATUS read value:
  - bit 0 `busy` = FSM not IDLE or FIFO not empty.
  - bit 1 `full`.
  - bit 2 `empty`.
  - bits [3+:$clog2(FIFO_DEPTH)+1] `count`.
  - bit 15 `ovf`.
  - All other bits are 0.
- FIFO: circular buffer with read and write pointers of width $clog2(FIFO_DEPTH) that wrap modulo depth, plus a separate count.
  - Push and pop on the same edge (not full, not empty) leave count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - A bit counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - An index counter runs 0..7 in DATA.
- IDLE: `tx`=1. If the FIFO is non-empty: pop into shift register, clear bit counter, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA: `tx`=shift[0], sending LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After index 7 completes, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `tx` is registered: driven from a flop updated on the state-entry edge, so it is glitch-free.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - `tx`=1, FSM IDLE, FIFO empty, pointers/count/counters 0, `ovf`=0, shift register 0.
  - Therefore `ReadData` at STATUS reads 32'h4.
- Reset mid-frame: the frame is aborted, `tx` goes high immediately (asynchronous), and FIFO contents are lost.
- DATA write accepted at edge k:
  - count becomes 1 after edge k.
  - If the FSM was IDLE, the pop occurs at edge k+1 and `tx` falls after edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles from `tx` falling to the end of STOP.
- Back-to-back bytes: the FSM spends exactly 1 cycle in IDLE between frames, so the inter-frame gap is 1 clk of extra high.
- `busy` falls the cycle after STOP ends if the FIFO is empty.
- STATUS reflects register state after the most recent edge. There is no read side effect.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'hFF201000.
- Reset: hold reset_n=0 for 3 cycles, then release. Expect `tx`=1 and STATUS ReadData=32'h00000004, `sel`=1 at 32'hFF201004, `sel`=0 at 32'hFF200000.
- Single byte: write 32'hABCD0055 at edge k. Expect:
  - `tx` low after edge k+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles (40 cycles total).
  - STATUS[0]=1 throughout, then STATUS returns to 32'h4.
- Overflow: write 8'h01–8'h06 on 6 consecutive edges. Expect:
  - Bytes 01,02,03,04,05 transmitted in order, each separated by a 1-cycle gap; 06 never appears.
  - STATUS shows full=1, count=4 and bit 15=1.
  - A CTRL write of 32'h1 then clears bit 15.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of a frame. Expect `tx`=1 immediately (asynchronous), STATUS=32'h4 after release, and no residual frame.
- Decode: writes to 32'hFF20100C and 32'hFF201001 leave count=0 and `tx`=1. A read at 32'hFF201000 returns 0.
- Simultaneous push and pop: with count=1 and the FSM in IDLE, write on the same edge as the pop. Expect count stays 1 and the bytes are transmitted in FIFO order.
